// File: rtl/wb_dbg_master.sv
// Wishbone pipelined debug master: UART byte commands become single bus accesses with a byte reply.
// Build option WB_DBG_AUTOINC_EN: post-increment stored address, plus 'w'/'r' commands on that address.
module wb_dbg_master #(
    parameter int WB_TIMEOUT = 256,
    parameter int RX_TIMEOUT = 1000000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_stb_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_stb_o,
    input  logic        tx_busy_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_stall_i,
    output logic        busy_o
);

    localparam int WB_CW = $clog2(WB_TIMEOUT + 1);
    localparam int RX_CW = $clog2(RX_TIMEOUT + 1);
    localparam logic [WB_CW-1:0] WB_LAST = WB_CW'(WB_TIMEOUT - 1);
    localparam logic [RX_CW-1:0] RX_LAST = RX_CW'(RX_TIMEOUT - 1);

    localparam logic [7:0] CMD_W  = 8'h57;
    localparam logic [7:0] CMD_R  = 8'h52;
    localparam logic [7:0] CMD_WI = 8'h77;
    localparam logic [7:0] CMD_RI = 8'h72;
    localparam logic [7:0] RSP_K  = 8'h4B;
    localparam logic [7:0] RSP_D  = 8'h44;
    localparam logic [7:0] RSP_E  = 8'h45;
    localparam logic [7:0] RSP_Q  = 8'h3F;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_WB_REQ  = 3'd3,
        S_WB_WAIT = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_cmd_we;
    logic [1:0]        r_byte_cnt;
    logic [31:0]       r_shift;
    logic [31:0]       r_adr;
    logic [31:0]       r_dat;
    logic              r_cyc;
    logic              r_stb;
    logic              r_we;
    logic [WB_CW-1:0]  r_wb_cnt;
    logic [RX_CW-1:0]  r_rx_cnt;
    logic [39:0]       r_resp;
    logic [2:0]        r_resp_len;
    logic [7:0]        r_tx_data;
    logic              r_tx_stb;
    logic              r_busy;

    logic              w_take;
    logic              w_unknown;
    logic              w_field_done;
    logic              w_bus_start;
    logic              w_bus_end;
    logic              w_bus_ok;
    logic              w_tx_fire;
    logic [31:0]       w_field;

    assign w_field = {r_shift[23:0], rx_data_i};

    // State register
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_unknown    = 1'b0;
        w_field_done = 1'b0;
        w_bus_start  = 1'b0;
        w_bus_end    = 1'b0;
        w_bus_ok     = 1'b0;
        w_tx_fire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rx_stb_i) begin
                    w_take = 1'b1;
                    case (rx_data_i)
                        CMD_W, CMD_R: w_next_state = S_ADDR;
`ifdef WB_DBG_AUTOINC_EN
                        CMD_WI:       w_next_state = S_DATA;
                        CMD_RI: begin
                            w_next_state = S_WB_REQ;
                            w_bus_start  = 1'b1;
                        end
`endif
                        default: begin
                            w_next_state = S_RESP;
                            w_unknown    = 1'b1;
                        end
                    endcase
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_ADDR: begin
                if (rx_stb_i) begin
                    w_take = 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        w_field_done = 1'b1;
                        if (r_cmd_we) begin
                            w_next_state = S_DATA;
                        end else begin
                            w_next_state = S_WB_REQ;
                            w_bus_start  = 1'b1;
                        end
                    end else begin
                        w_next_state = S_ADDR;
                    end
                end else if (r_rx_cnt == RX_LAST) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_ADDR;
                end
            end
            S_DATA: begin
                if (rx_stb_i) begin
                    w_take = 1'b1;
                    if (r_byte_cnt == 2'd3) begin
                        w_field_done = 1'b1;
                        w_next_state = S_WB_REQ;
                        w_bus_start  = 1'b1;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end else if (r_rx_cnt == RX_LAST) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_WB_REQ: begin
                // A response in the acceptance cycle completes the access outright
                if (!wbm_stall_i && (wbm_ack_i || wbm_err_i)) begin
                    w_bus_end    = 1'b1;
                    w_bus_ok     = wbm_ack_i && !wbm_err_i;
                    w_next_state = S_RESP;
                end else if (r_wb_cnt == WB_LAST) begin
                    w_bus_end    = 1'b1;
                    w_next_state = S_RESP;
                end else if (!wbm_stall_i) begin
                    w_next_state = S_WB_WAIT;
                end else begin
                    w_next_state = S_WB_REQ;
                end
            end
            S_WB_WAIT: begin
                if (wbm_ack_i || wbm_err_i) begin
                    w_bus_end    = 1'b1;
                    w_bus_ok     = wbm_ack_i && !wbm_err_i;
                    w_next_state = S_RESP;
                end else if (r_wb_cnt == WB_LAST) begin
                    w_bus_end    = 1'b1;
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_WB_WAIT;
                end
            end
            S_RESP: begin
                // r_tx_stb blocks back-to-back pulses so the UART can raise busy
                if (!tx_busy_i && !r_tx_stb) begin
                    w_tx_fire = 1'b1;
                    if (r_resp_len == 3'd1) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_state = S_RESP;
                    end
                end else begin
                    w_next_state = S_RESP;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Command parser: byte counter, field shift register, inter-byte timeout
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_cmd_we   <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_shift    <= 32'h0000_0000;
            r_rx_cnt   <= {RX_CW{1'b0}};
        end else begin
            if (w_take) begin
                r_rx_cnt <= {RX_CW{1'b0}};
            end else if (r_state == S_ADDR || r_state == S_DATA) begin
                r_rx_cnt <= r_rx_cnt + RX_CW'(1);
            end else begin
                r_rx_cnt <= {RX_CW{1'b0}};
            end
            if (w_take && r_state == S_IDLE) begin
                r_cmd_we   <= (rx_data_i == CMD_W) || (rx_data_i == CMD_WI);
                r_byte_cnt <= 2'd0;
            end else if (w_take) begin
                r_shift    <= w_field;
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end
        end
    end

    // Wishbone request side: address/data latches, cyc/stb/we, access timeout
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_adr    <= 32'h0000_0000;
            r_dat    <= 32'h0000_0000;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_wb_cnt <= {WB_CW{1'b0}};
        end else begin
            if (w_field_done && r_state == S_ADDR) begin
                r_adr <= w_field;
            end
`ifdef WB_DBG_AUTOINC_EN
            else if (w_bus_end && w_bus_ok) begin
                r_adr <= r_adr + 32'd4;
            end
`endif
            if (w_field_done && r_state == S_DATA) begin
                r_dat <= w_field;
            end
            if (w_bus_start) begin
                r_cyc    <= 1'b1;
                r_stb    <= 1'b1;
                r_we     <= r_cmd_we && (r_state != S_IDLE);
                r_wb_cnt <= {WB_CW{1'b0}};
            end else if (w_bus_end) begin
                r_cyc <= 1'b0;
                r_stb <= 1'b0;
                r_we  <= 1'b0;
            end else begin
                if (r_state == S_WB_REQ && !wbm_stall_i) begin
                    r_stb <= 1'b0;
                end
                r_wb_cnt <= r_wb_cnt + WB_CW'(1);
            end
        end
    end

    // Reply buffer and transmit strobe
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_resp     <= 40'h00_0000_0000;
            r_resp_len <= 3'd0;
            r_tx_data  <= 8'h00;
            r_tx_stb   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_tx_stb <= w_tx_fire;
            r_busy   <= (w_next_state != S_IDLE);
            if (w_unknown) begin
                r_resp     <= {RSP_Q, 32'h0000_0000};
                r_resp_len <= 3'd1;
            end else if (w_bus_end) begin
                if (!w_bus_ok) begin
                    r_resp     <= {RSP_E, 32'h0000_0000};
                    r_resp_len <= 3'd1;
                end else if (r_we) begin
                    r_resp     <= {RSP_K, 32'h0000_0000};
                    r_resp_len <= 3'd1;
                end else begin
                    r_resp     <= {RSP_D, wbm_dat_i};
                    r_resp_len <= 3'd5;
                end
            end else if (w_tx_fire) begin
                r_tx_data  <= r_resp[39:32];
                r_resp     <= {r_resp[31:0], 8'h00};
                r_resp_len <= r_resp_len - 3'd1;
            end
        end
    end

    assign tx_data_o = r_tx_data;
    assign tx_stb_o  = r_tx_stb;
    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_stb;
    assign wbm_we_o  = r_we;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;
    assign wbm_sel_o = 4'hF;
    assign busy_o    = r_busy;

endmodule
